// File: rtl/seq_shift_add_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   DEFAULT_WIDTH : default operand width in bits
//   state_t       : control FSM states (IDLE, RUN, FIX)
package seq_shift_add_mult_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_shift_add_mult_twos_negate.sv
// Combinational two's-complement negation (invert plus one).
// Ports:
//   value : operand to negate
//   neg_c : -value modulo 2^WIDTH (combinational)
module twos_negate #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] neg_c
);

    assign neg_c = ~value + WIDTH'(1);

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier, signed or unsigned, fixed latency.
// Operands are reduced to magnitudes at load, multiplied with one
// WIDTH+1-bit adder over WIDTH RUN cycles, and the product sign is
// reapplied in FIX as the result is registered.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   start     : request a multiply (only honoured in IDLE)
//   is_signed : 1 = two's-complement operands, sampled with start
//   m, q      : multiplicand and multiplier, sampled with start
//   busy      : operation in progress
//   done      : one-cycle pulse when result is updated
//   result    : 2*WIDTH-bit product, held until the next done
module seq_shift_add_mult
    import seq_shift_add_mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     m,
    input  logic [WIDTH-1:0]     q,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int unsigned SUM_W  = WIDTH + 1;
    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t state;
    state_t state_next;

    logic load;
    logic step;
    logic finish;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic             prod_neg;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0]  m_neg_c;
    logic [WIDTH-1:0]  q_neg_c;
    logic [WIDTH-1:0]  m_mag_c;
    logic [WIDTH-1:0]  q_mag_c;
    logic [WIDTH-1:0]  addend_c;
    logic [SUM_W-1:0]  sum_c;
    logic [PROD_W-1:0] prod_c;
    logic [PROD_W-1:0] prod_neg_c;

    // Operand magnitudes; most-negative maps to 2^(WIDTH-1) as unsigned.
    twos_negate #(.WIDTH(WIDTH)) u_neg_m (
        .value (m),
        .neg_c (m_neg_c)
    );

    twos_negate #(.WIDTH(WIDTH)) u_neg_q (
        .value (q),
        .neg_c (q_neg_c)
    );

    // Sign fix of the unsigned magnitude product.
    twos_negate #(.WIDTH(PROD_W)) u_neg_prod (
        .value (prod_c),
        .neg_c (prod_neg_c)
    );

    assign m_mag_c = (is_signed && m[WIDTH-1]) ? m_neg_c : m;
    assign q_mag_c = (is_signed && q[WIDTH-1]) ? q_neg_c : q;

    // The single datapath adder; carry lands in sum_c[WIDTH].
    assign addend_c = mplier[0] ? mcand : WIDTH'(0);
    assign sum_c    = {1'b0, acc} + {1'b0, addend_c};

    // Multiplier bits shift out as product bits shift in from the top.
    assign prod_c = {acc, mplier};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            prod_neg <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
        end else begin
            done <= finish;
            if (load) begin
                mcand    <= m_mag_c;
                mplier   <= q_mag_c;
                acc      <= '0;
                cnt      <= '0;
                prod_neg <= is_signed & (m[WIDTH-1] ^ q[WIDTH-1]);
                busy     <= 1'b1;
            end else if (step) begin
                // {carry, acc, mplier} >> 1 with the fresh sum in the top.
                acc    <= sum_c[SUM_W-1:1];
                mplier <= {sum_c[0], mplier[WIDTH-1:1]};
                cnt    <= cnt + CNT_W'(1);
            end
            if (finish) begin
                result <= prod_neg ? prod_neg_c : prod_c;
                busy   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Scoreboard bench for seq_shift_add_mult at WIDTH=8 and WIDTH=32.
module tb_seq_shift_add_mult;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 8-bit instance
    logic        start8, sg8, busy8, done8;
    logic [7:0]  m8, q8;
    logic [15:0] result8;

    seq_shift_add_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .is_signed(sg8),
        .m(m8), .q(q8), .busy(busy8), .done(done8), .result(result8)
    );

    // 32-bit instance
    logic        start32, sg32, busy32, done32;
    logic [31:0] m32, q32;
    logic [63:0] result32;

    seq_shift_add_mult #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .is_signed(sg32),
        .m(m32), .q(q32), .busy(busy32), .done(done32), .result(result32)
    );

    typedef struct {
        logic [63:0] res;
        int unsigned acc;
    } exp_t;

    typedef struct {
        logic        sg;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec8_t;

    exp_t  sb8[$];
    exp_t  sb32[$];
    exp_t  e8, e32;
    vec8_t vecs[$];
    vec8_t b2b[$];

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned acc_cyc8;
    int unsigned prev_acc;
    logic prev_done8 = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [15:0] model8(input logic sg, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] ea, eb;
        ea = sg ? {{8{a[7]}}, a} : {8'h00, a};
        eb = sg ? {{8{b[7]}}, b} : {8'h00, b};
        return 16'(ea * eb);
    endfunction

    // Monitors: pop expectation whenever done is presented.
    always @(negedge clk) begin
        if (done8) begin
            check("done8_has_pending_start", 64'(sb8.size() > 0), 64'd1);
            if (sb8.size() > 0) begin
                e8 = sb8.pop_front();
                check("result8", 64'(result8), e8.res);
                check("latency8", 64'(cyc - e8.acc), 64'd9);
                check("busy8_low_with_done", 64'(busy8), 64'd0);
            end
        end
        if (prev_done8) check("done8_single_cycle", 64'(done8), 64'd0);
        prev_done8 = done8;
    end

    always @(negedge clk) begin
        if (done32) begin
            check("done32_has_pending_start", 64'(sb32.size() > 0), 64'd1);
            if (sb32.size() > 0) begin
                e32 = sb32.pop_front();
                check("result32", result32, e32.res);
                check("latency32", 64'(cyc - e32.acc), 64'd33);
            end
        end
    end

    // Called at a negedge with dut8 idle; the following edge accepts.
    task automatic issue8(input logic sg, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] p, input bit push, input bit hold);
        sg8 = sg; m8 = a; q8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        acc_cyc8 = cyc;
        if (push) sb8.push_back('{res: 64'(p), acc: cyc});
        check("accept8_busy", 64'(busy8), 64'd1);
        if (!hold) start8 = 1'b0;
        // Scramble inputs: the in-flight product must not see them.
        m8 = 8'($urandom); q8 = 8'($urandom); sg8 = 1'($urandom);
    endtask

    task automatic wait_idle8();
        int n;
        n = 0;
        @(negedge clk);
        while (busy8 !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("idle8_within_bound", 64'(busy8), 64'd0);
    endtask

    task automatic issue32(input logic sg, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] p);
        int n;
        sg32 = sg; m32 = a; q32 = b; start32 = 1'b1;
        @(posedge clk); #1;
        sb32.push_back('{res: p, acc: cyc});
        check("accept32_busy", 64'(busy32), 64'd1);
        start32 = 1'b0;
        m32 = $urandom; q32 = $urandom; sg32 = 1'($urandom);
        n = 0;
        @(negedge clk);
        while (busy32 !== 1'b0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        check("idle32_within_bound", 64'(busy32), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{1'b0, 8'hFF, 8'hFF, 16'hFE01});
        vecs.push_back('{1'b1, 8'h80, 8'h80, 16'h4000});
        vecs.push_back('{1'b1, 8'h80, 8'h01, 16'hFF80});
        vecs.push_back('{1'b1, 8'hFD, 8'h07, 16'hFFEB});
        vecs.push_back('{1'b1, 8'hFF, 8'hFF, 16'h0001});
        vecs.push_back('{1'b0, 8'h80, 8'h80, 16'h4000});
        vecs.push_back('{1'b1, 8'h7F, 8'h80, 16'hC080});
        vecs.push_back('{1'b0, 8'h00, 8'hFF, 16'h0000});
        vecs.push_back('{1'b1, 8'h00, 8'h80, 16'h0000});
        vecs.push_back('{1'b0, 8'h0F, 8'h11, 16'h00FF});
        vecs.push_back('{1'b1, 8'h7F, 8'h7F, 16'h3F01});
        vecs.push_back('{1'b0, 8'hFF, 8'h01, 16'h00FF});
        vecs.push_back('{1'b1, 8'hFF, 8'h01, 16'hFFFF});
        b2b.push_back('{1'b1, 8'hFD, 8'h07, 16'hFFEB});
        b2b.push_back('{1'b0, 8'hFF, 8'hFF, 16'hFE01});
        b2b.push_back('{1'b1, 8'h80, 8'h80, 16'h4000});

        rst = 1'b1;
        start8 = 1'b0; sg8 = 1'b0; m8 = '0; q8 = '0;
        start32 = 1'b0; sg32 = 1'b0; m32 = '0; q32 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy8", 64'(busy8), 64'd0);
        check("reset_done8", 64'(done8), 64'd0);
        check("reset_result8", 64'(result8), 64'd0);
        check("reset_busy32", 64'(busy32), 64'd0);
        check("reset_result32", result32, 64'd0);
        rst = 1'b0;

        // 32-bit directed products
        issue32(1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFE);
        issue32(1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE);
        issue32(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);

        // 8-bit directed products
        foreach (vecs[i]) begin
            issue8(vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].p, 1'b1, 1'b0);
            wait_idle8();
        end
        repeat (3) @(negedge clk);
        check("result8_held", 64'(result8), 64'h0000_FFFF);

        // start pulse while busy must be ignored
        issue8(1'b0, 8'h12, 8'h34, 16'h03A8, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        start8 = 1'b1; m8 = 8'hAA; q8 = 8'h55;
        @(negedge clk);
        start8 = 1'b0;
        wait_idle8();
        repeat (12) @(negedge clk);

        // start held high: accepted only in done cycles, one per 10 cycles
        foreach (b2b[i]) begin
            issue8(b2b[i].sg, b2b[i].a, b2b[i].b, b2b[i].p, 1'b1, (i < 2));
            if (i > 0) check("b2b_gap8", 64'(acc_cyc8 - prev_acc), 64'd10);
            prev_acc = acc_cyc8;
            wait_idle8();
        end

        // reset 4 cycles into RUN aborts without done
        issue8(1'b0, 8'h12, 8'h34, 16'h0000, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; start8 = 1'b1; m8 = 8'h03; q8 = 8'h05;
        @(negedge clk);
        check("abort_busy8", 64'(busy8), 64'd0);
        check("abort_done8", 64'(done8), 64'd0);
        check("abort_result8", 64'(result8), 64'd0);
        rst = 1'b0; start8 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort_no_done8", 64'(done8), 64'd0);
        end
        issue8(1'b1, 8'hFD, 8'h07, 16'hFFEB, 1'b1, 1'b0);
        wait_idle8();

        // a few random operands against the bench's own model
        for (int i = 0; i < 24; i++) begin
            logic sg;
            logic [7:0] a, b;
            sg = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
            issue8(sg, a, b, model8(sg, a, b), 1'b1, 1'b0);
            wait_idle8();
        end

        repeat (5) @(negedge clk);
        check("sb8_drained", 64'(sb8.size()), 64'd0);
        check("sb32_drained", 64'(sb32.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_shift_add_mult.md
SEQ_SHIFT_ADD_MULT -- requirements
Module: seq_shift_add_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; legal range 4..64.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request a multiply; sampled only in IDLE.
REQ-005 SHALL have port is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL have port m  input  WIDTH  multiplicand; sampled with start.
REQ-007 SHALL have port q  input  WIDTH  multiplier; sampled with start.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse, result updated.
REQ-010 SHALL have port result  output  2*WIDTH  product, held until next done.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, FIX; one shift-add iteration per RUN cycle.
REQ-012 In IDLE with start=1 at edge k, SHALL latch operands and is_signed, go to RUN, and assert busy from edge k onward.
REQ-013 On load, SHALL replace each operand by its magnitude when is_signed=1 and its MSB=1; product sign = XOR of operand MSBs when signed, else 0.
REQ-014 Each RUN cycle: if multiplier LSB=1, add multiplicand magnitude to accumulator with carry kept (WIDTH+1 bits); shift {carry, accumulator, multiplier} right by one.
REQ-015 RUN SHALL last exactly WIDTH cycles (edges k+1..k+WIDTH), counted by a ceil(log2(WIDTH+1))-bit counter; then go to FIX.
REQ-016 At edge k+WIDTH+1 (FIX -> IDLE), SHALL register result (two's-complement negated if product sign=1), drive done=1 for exactly that cycle, and deassert busy.
REQ-017 Latency: done is high WIDTH+1 cycles after the start-accept edge; fixed and independent of operand values.
REQ-018 start while busy=1 SHALL be ignored and have no effect on the in-flight operation.
REQ-019 start=1 in the cycle done=1 SHALL be accepted (back-to-back); throughput one product per WIDTH+2 cycles.
REQ-020 Signed most-negative times most-negative SHALL yield +2^(2*WIDTH-2) exactly; no overflow in any mode.
REQ-021 A zero operand SHALL NOT shorten latency.
REQ-022 Changes on m, q, is_signed after acceptance SHALL NOT affect the in-flight product.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE and set busy=0, done=0, result=0, and clear accumulator, counter and operand registers.
REQ-024 rst mid-operation SHALL abort it with no done pulse; start is ignored while rst=1.
REQ-025 rst SHALL take priority over every other input.

Structure
REQ-026 A shared package SHALL hold the FSM state type (IDLE, RUN, FIX) and the default WIDTH constant.
REQ-027 One sub-module, twos_negate (parametrised width, combinational invert-plus-one), SHALL be instantiated for operand magnitude and for result sign fix.
REQ-028 Datapath SHALL use one WIDTH+1-bit adder only; no array multiplier.

Verification
REQ-029 WIDTH=8, unsigned, m=0xFF, q=0xFF, start pulse -> done exactly 9 cycles after acceptance edge, result=0xFE01, busy low with done.
REQ-030 WIDTH=8, signed, m=0x80, q=0x80 -> result=0x4000; m=0x80, q=0x01 -> result=0xFF80; m=0xFD (-3), q=0x07 -> result=0xFFEB.
REQ-031 WIDTH=32, signed, m=0xFFFFFFFF, q=0x00000002 -> result=0xFFFFFFFFFFFFFFFE; unsigned same operands -> result=0x00000001FFFFFFFE.
REQ-032 WIDTH=8: start held high continuously with changing operands -> each accepted only at done cycle, one product per 10 cycles, mid-flight operand changes ignored.
REQ-033 WIDTH=8: rst asserted 4 cycles into RUN -> next cycle busy=0, result=0, no done; new start after rst release completes normally.
REQ-034 Randomised WIDTH=16, both modes, 10k ops -> result matches reference product; done never asserted without preceding accepted start.
